// File: rtl/ccg_response_misr_if.sv
// Valid/ready stream carrying one circuit-under-test output vector per transfer.
interface ccg_response_misr_if #(
  parameter int unsigned OUT_W = 23
) ();
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ccg_response_misr.sv
// Response compactor: folds accepted output vectors into a Galois MISR signature,
// a vector count and a running ones-count for netlist variant labelling.
module ccg_response_misr #(
  parameter int unsigned      OUT_W = 23,
  parameter int unsigned      SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF,
  parameter int unsigned      CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_vec,
  ccg_response_misr_if.slave   in_if,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_W-1:0]     signature,
  output logic [CNT_W-1:0]     vec_count,
  output logic [CNT_W+4:0]     ones_sum
);

  localparam int unsigned SUM_W = CNT_W + 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             load_c;
  logic             accept_c;
  logic             last_c;
  logic             in_ready_q;
  logic [CNT_W-1:0] num_vec_q;
  logic [CNT_W-1:0] count_inc_c;

  assign in_if.in_ready = in_ready_q;
  assign accept_c       = in_if.in_valid & in_ready_q;
  assign count_inc_c    = CNT_W'(vec_count + CNT_W'(1));
  assign last_c         = (count_inc_c == num_vec_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; start only acts outside RUN
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = (num_vec == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept_c && last_c) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags registered from the next state so they line up with state_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      busy       <= (state_d == S_RUN);
      done       <= (state_d == S_DONE);
      in_ready_q <= (state_d == S_RUN);
    end
  end

  // Result datapath: preload on start, fold on each accepted vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_vec_q <= '0;
      signature <= '0;
      vec_count <= '0;
      ones_sum  <= '0;
    end else if (load_c) begin
      num_vec_q <= num_vec;
      signature <= SEED;
      vec_count <= '0;
      ones_sum  <= '0;
    end else if (accept_c) begin
      signature <= {signature[SIG_W-2:0], 1'b0}
                 ^ (signature[SIG_W-1] ? POLY : '0)
                 ^ SIG_W'(in_if.in_data);
      vec_count <= count_inc_c;
      ones_sum  <= SUM_W'(ones_sum + SUM_W'($countones(in_if.in_data)));
    end
  end

endmodule

// File: tb/tb_ccg_response_misr.sv
// Randomized self-checking bench for ccg_response_misr against an arithmetic MISR model.
module tb_ccg_response_misr;

  localparam int unsigned OUT_W = 23;
  localparam int unsigned SIG_W = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] SEED  = 32'hFFFFFFFF;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W+4:0] ones_sum;

  int tests = 0;
  int fails = 0;

  logic [OUT_W-1:0] vecs [0:99];

  ccg_response_misr_if #(.OUT_W(OUT_W)) bus ();

  ccg_response_misr dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_vec   (num_vec),
    .in_if     (bus.slave),
    .busy      (busy),
    .done      (done),
    .signature (signature),
    .vec_count (vec_count),
    .ones_sum  (ones_sum)
  );

  always #5 clk = ~clk;

  // Signature as polynomial arithmetic: multiply by x modulo POLY, then add the vector
  function automatic logic [31:0] model_step(input logic [31:0] sig, input logic [OUT_W-1:0] d);
    logic [32:0] wide;
    wide = {sig, 1'b0};
    if (wide[32]) wide = wide ^ {1'b1, POLY};
    return wide[31:0] ^ {9'd0, d};
  endfunction

  function automatic int model_ones(input logic [OUT_W-1:0] d);
    int n = 0;
    for (int i = 0; i < OUT_W; i++) n += int'(d[i]);
    return n;
  endfunction

  task automatic do_start(input logic [CNT_W-1:0] nv);
    @(negedge clk);
    start   = 1'b1;
    num_vec = nv;
    @(negedge clk);
    start   = 1'b0;
    num_vec = CNT_W'($urandom);
  endtask

  // Stream vecs[0..n-1] honouring in_ready; returns just after the edge of the last accept
  task automatic send(input int n, input int gap_pct, input int start_pct, output bit ok);
    int idx = 0;
    int budget = 2000;
    bit v;
    bit rdy;
    while (idx < n && budget > 0) begin
      @(negedge clk);
      v = ($urandom_range(99) >= gap_pct);
      bus.in_valid = v;
      bus.in_data  = v ? vecs[idx] : OUT_W'($urandom);
      if (idx > 0 && $urandom_range(99) < start_pct) begin
        start   = 1'b1;
        num_vec = CNT_W'($urandom_range(3));
      end
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
      bus.in_valid = 1'b0;
      if (v && rdy) idx++;
      budget--;
    end
    ok = (idx == n);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; num_vec = '0;
    bus.in_valid = 1'b1; bus.in_data = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if (bus.in_ready !== 1'b0 || signature !== 32'h0 || vec_count !== 16'h0 ||
          done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d: rdy=%b sig=%h cnt=%0d done=%b busy=%b, required 0/0/0/0/0",
                 c, bus.in_ready, signature, vec_count, done, busy);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_zero_vec;
    do_start(16'd0);
    tests++;
    if (done !== 1'b1 || signature !== SEED || vec_count !== 16'h0 || ones_sum !== '0 ||
        bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL zero_vec: done=%b sig=%h cnt=%0d ones=%0d rdy=%b, required 1/%h/0/0/0",
               done, signature, vec_count, ones_sum, bus.in_ready, SEED);
    end
  endtask

  task automatic test_single;
    bit ok;
    vecs[0] = 23'h000001;
    do_start(16'd1);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL single_busy: busy=%b done=%b, required 1/0", busy, done);
    end
    send(1, 0, 0, ok);
    @(negedge clk);
    tests++;
    if (!ok || done !== 1'b1 || signature !== 32'hFB3EE248 || ones_sum !== 21'd1 || vec_count !== 16'd1) begin
      fails++;
      $display("FAIL single: ok=%b done=%b sig=%h ones=%0d cnt=%0d, required 1/1/fb3ee248/1/1",
               ok, done, signature, ones_sum, vec_count);
    end
  endtask

  task automatic test_four_ones;
    bit ok;
    logic [31:0] exp_sig = SEED;
    for (int i = 0; i < 4; i++) begin
      vecs[i] = '1;
      exp_sig = model_step(exp_sig, vecs[i]);
    end
    do_start(16'd4);
    send(4, 40, 0, ok);
    // a fifth vector is offered continuously and must be refused
    bus.in_valid = 1'b1; bus.in_data = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (!ok || done !== 1'b1 || bus.in_ready !== 1'b0 || vec_count !== 16'd4 ||
          ones_sum !== 21'd92 || signature !== exp_sig) begin
        fails++;
        $display("FAIL four_ones cyc=%0d: ok=%b done=%b rdy=%b cnt=%0d ones=%0d sig=%h, required 1/1/0/4/92/%h",
                 c, ok, done, bus.in_ready, vec_count, ones_sum, signature, exp_sig);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    logic [31:0] exp_sig = SEED;
    int exp_ones = 0;
    for (int i = 0; i < 6; i++) vecs[i] = OUT_W'($urandom);
    do_start(16'd6);
    send(2, 0, 0, ok);
    rst = 1'b1;
    #1;
    tests++;
    if (!ok || signature !== 32'h0 || vec_count !== 16'h0 || ones_sum !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: ok=%b sig=%h cnt=%0d ones=%0d busy=%b done=%b rdy=%b, required all 0",
               ok, signature, vec_count, ones_sum, busy, done, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: busy=%b done=%b, required 0/0", busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      exp_sig  = model_step(exp_sig, vecs[i]);
      exp_ones += model_ones(vecs[i]);
    end
    do_start(16'd3);
    send(3, 30, 0, ok);
    @(negedge clk);
    tests++;
    if (!ok || done !== 1'b1 || signature !== exp_sig || ones_sum !== 21'(exp_ones) || vec_count !== 16'd3) begin
      fails++;
      $display("FAIL fresh_run: ok=%b done=%b sig=%h ones=%0d cnt=%0d, required 1/1/%h/%0d/3",
               ok, done, signature, ones_sum, vec_count, exp_sig, exp_ones);
    end
  endtask

  task automatic test_random_100;
    bit ok;
    logic [31:0] exp_sig = SEED;
    int exp_ones = 0;
    int gaps [0:2] = '{0, 50, 30};
    int starts [0:2] = '{0, 0, 20};
    for (int i = 0; i < 100; i++) begin
      vecs[i]  = OUT_W'($urandom);
      exp_sig  = model_step(exp_sig, vecs[i]);
      exp_ones += model_ones(vecs[i]);
    end
    for (int r = 0; r < 3; r++) begin
      do_start(16'd100);
      send(100, gaps[r], starts[r], ok);
      @(negedge clk);
      tests++;
      if (!ok || done !== 1'b1 || signature !== exp_sig || ones_sum !== 21'(exp_ones) || vec_count !== 16'd100) begin
        fails++;
        $display("FAIL random100 run=%0d: ok=%b done=%b sig=%h ones=%0d cnt=%0d, required 1/1/%h/%0d/100",
                 r, ok, done, signature, ones_sum, vec_count, exp_sig, exp_ones);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    for (int r = 0; r < 4; r++) begin
      logic [31:0] exp_sig = SEED;
      int exp_ones = 0;
      int n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        vecs[i]  = OUT_W'($urandom);
        exp_sig  = model_step(exp_sig, vecs[i]);
        exp_ones += model_ones(vecs[i]);
      end
      do_start(CNT_W'(n));
      send(n, 25, 0, ok);
      @(negedge clk);
      tests++;
      if (!ok || done !== 1'b1 || signature !== exp_sig || ones_sum !== 21'(exp_ones) || vec_count !== CNT_W'(n)) begin
        fails++;
        $display("FAIL back_to_back run=%0d n=%0d: ok=%b done=%b sig=%h ones=%0d cnt=%0d, required 1/1/%h/%0d/%0d",
                 r, n, ok, done, signature, ones_sum, vec_count, exp_sig, exp_ones, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_vec();
    test_single();
    test_four_ones();
    test_reset_mid_run();
    test_random_100();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
